// File: rtl/ifetch.sv
// Instruction fetch front end: walks a combinational ROM and queues {pc, word} pairs for decode.
// Optional define IFETCH_LE_SWAP_EN byte-reverses each fetched word before it is queued.
module ifetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        fault
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    ST_RUN,
    ST_FAULT
  } state_e;

  state_e             state_q,    state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]   count_q,    count_d;
  logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [31:0]        pc_mem_q   [FIFO_DEPTH];
  logic [31:0]        data_mem_q [FIFO_DEPTH];

  logic        push;
  logic        pop;
  logic [31:0] wr_word;

`ifdef IFETCH_LE_SWAP_EN
  assign wr_word = {rom_data[7:0], rom_data[15:8], rom_data[23:16], rom_data[31:24]};
`else
  assign wr_word = rom_data;
`endif

  assign rom_addr   = fetch_pc_q;
  assign inst_valid = (count_q != '0) && (state_q == ST_RUN);
  assign inst_pc    = pc_mem_q[rd_ptr_q];
  assign inst_data  = data_mem_q[rd_ptr_q];
  assign fault      = (state_q == ST_FAULT);

  // A redirect voids any handshake in its cycle, so it gates both pop and push.
  assign pop  = inst_valid & inst_ready & ~redirect_valid;
  assign push = (state_q == ST_RUN) & ~redirect_valid & ((count_q < DEPTH_C) | pop);

  // NOTE: every next-state signal is given its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (redirect_valid) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      if (redirect_pc[1:0] == 2'b00) begin
        fetch_pc_d = redirect_pc;
        state_d    = ST_RUN;
      end else begin
        state_d    = ST_FAULT;
      end
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // NOTE: the buffer is tiny and its head must read 0 out of reset, so it is reset rather than left undefined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
      data_mem_q[wr_ptr_q] <= wr_word;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: table of per-cycle vectors plus hand sequences for reset,
// address wrap, fault recovery and the byte-swap option.
module tb_ifetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        fault;

  logic        rst2_n;
  logic [31:0] rom_addr2;
  logic [31:0] rom_data2;
  logic        inst_valid2;
  logic [31:0] inst_data2;
  logic [31:0] inst_pc2;
  logic        fault2;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h1122_3344;
    return 32'h1000_0000 + (a >> 2);
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] a);
    logic [31:0] w;
    w = rom_word(a);
`ifdef IFETCH_LE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  assign rom_data  = rom_word(rom_addr);
  assign rom_data2 = rom_word(rom_addr2);

  ifetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .fault          (fault)
  );

  ifetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk            (clk),
    .rst_n          (rst2_n),
    .rom_addr       (rom_addr2),
    .rom_data       (rom_data2),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .inst_valid     (inst_valid2),
    .inst_data      (inst_data2),
    .inst_pc        (inst_pc2),
    .inst_ready     (1'b1),
    .fault          (fault2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_addr;
    logic        e_fault;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rpc,
                              input logic ev, input logic [31:0] epc,
                              input logic [31:0] eaddr, input logic ef);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.e_valid = ev; v.e_pc = epc; v.e_addr = eaddr; v.e_fault = ef;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_rows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      inst_ready     = tbl[i].rdy;
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      #1;
      check($sformatf("row%0d valid", i), {31'b0, inst_valid}, {31'b0, tbl[i].e_valid});
      check($sformatf("row%0d fault", i), {31'b0, fault}, {31'b0, tbl[i].e_fault});
      check($sformatf("row%0d rom_addr", i), rom_addr, tbl[i].e_addr);
      if (tbl[i].e_valid) begin
        check($sformatf("row%0d inst_pc", i), inst_pc, tbl[i].e_pc);
        check($sformatf("row%0d inst_data", i), inst_data, exp_data(tbl[i].e_pc));
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " valid"}, {31'b0, inst_valid}, 32'd0);
    check({tag, " fault"}, {31'b0, fault}, 32'd0);
    check({tag, " rom_addr"}, rom_addr, 32'h0);
    check({tag, " inst_pc"}, inst_pc, 32'h0);
    check({tag, " inst_data"}, inst_data, 32'h0);
  endtask

  // Synchronous-style reset with a redirect pulse held during it; release lands mid-high phase.
  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    @(posedge clk);
    #2;
    check_reset_outputs("reset");
    redirect_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Reset asserted between edges: outputs must clear without waiting for a clock.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    redirect_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  logic [31:0] wrap_pcs [3];
  logic [31:0] swap_exp;

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // Free-running stream.
    tbl[0]  = mk(1, 0, 0, 0, 32'h0,  32'h0,  0);
    tbl[1]  = mk(1, 0, 0, 1, 32'h0,  32'h4,  0);
    tbl[2]  = mk(1, 0, 0, 1, 32'h4,  32'h8,  0);
    tbl[3]  = mk(1, 0, 0, 1, 32'h8,  32'hC,  0);
    tbl[4]  = mk(1, 0, 0, 1, 32'hC,  32'h10, 0);
    // Stall from reset, drain, redirect while full, misaligned fault, recovery.
    tbl[5]  = mk(0, 0, 0, 0, 32'h0,  32'h0,  0);
    tbl[6]  = mk(0, 0, 0, 1, 32'h0,  32'h4,  0);
    tbl[7]  = mk(0, 0, 0, 1, 32'h0,  32'h8,  0);
    tbl[8]  = mk(0, 0, 0, 1, 32'h0,  32'h8,  0);
    tbl[9]  = mk(0, 0, 0, 1, 32'h0,  32'h8,  0);
    tbl[10] = mk(0, 0, 0, 1, 32'h0,  32'h8,  0);
    tbl[11] = mk(1, 0, 0, 1, 32'h0,  32'h8,  0);
    tbl[12] = mk(1, 0, 0, 1, 32'h4,  32'hC,  0);
    tbl[13] = mk(1, 0, 0, 1, 32'h8,  32'h10, 0);
    tbl[14] = mk(1, 1, 32'h40, 1, 32'hC, 32'h14, 0);
    tbl[15] = mk(1, 0, 0, 0, 32'h0,  32'h40, 0);
    tbl[16] = mk(1, 0, 0, 1, 32'h40, 32'h44, 0);
    tbl[17] = mk(1, 1, 32'h42, 1, 32'h44, 32'h48, 0);
    tbl[18] = mk(1, 0, 0, 0, 32'h0,  32'h48, 1);
    tbl[19] = mk(1, 0, 0, 0, 32'h0,  32'h48, 1);
    tbl[20] = mk(1, 1, 32'h80, 0, 32'h0, 32'h48, 1);
    tbl[21] = mk(1, 0, 0, 0, 32'h0,  32'h80, 0);
    tbl[22] = mk(1, 0, 0, 1, 32'h80, 32'h84, 0);

    do_reset();
    run_rows(0, 4);
    do_reset();
    run_rows(5, 22);

    // Mid-stream async reset with a valid head, then resume from RESET_PC.
    async_reset("async_run");
    run_rows(0, 4);

    // Enter FAULT, then async reset must clear it immediately.
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h6;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("fault set", {31'b0, fault}, 32'd1);
    async_reset("async_fault");

    // Byte-order check on a known word.
    @(negedge clk);
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("swap gap valid", {31'b0, inst_valid}, 32'd0);
    @(negedge clk);
    #1;
`ifdef IFETCH_LE_SWAP_EN
    swap_exp = 32'h4433_2211;
`else
    swap_exp = 32'h1122_3344;
`endif
    check("swap valid", {31'b0, inst_valid}, 32'd1);
    check("swap pc", inst_pc, 32'h100);
    check("swap data", inst_data, swap_exp);

    // Address wrap from RESET_PC = FFFF_FFFC on the second instance.
    wrap_pcs[0] = 32'hFFFF_FFFC;
    wrap_pcs[1] = 32'h0000_0000;
    wrap_pcs[2] = 32'h0000_0004;
    @(negedge clk);
    #1;
    check("wrap reset addr", rom_addr2, 32'hFFFF_FFFC);
    check("wrap reset valid", {31'b0, inst_valid2}, 32'd0);
    rst2_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("wrap%0d valid", k), {31'b0, inst_valid2}, 32'd1);
      check($sformatf("wrap%0d pc", k), inst_pc2, wrap_pcs[k]);
      check($sformatf("wrap%0d data", k), inst_data2, exp_data(wrap_pcs[k]));
    end
    check("wrap fault", {31'b0, fault2}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
